// File: rtl/bp_me_mock_mem_responder_if.sv
// Memory command/response channel between a CCE/LCE-side initiator (master)
// and a memory responder (slave). Member names carry the responder's view.
interface bp_me_mock_mem_responder_if #(
    parameter int paddr_width_p   = 22,
    parameter int block_width_p   = 512,
    parameter int payload_width_p = 16
);
    logic                       mem_cmd_v_i;
    logic                       mem_cmd_ready_o;
    logic                       mem_cmd_opcode_i;
    logic [paddr_width_p-1:0]   mem_cmd_addr_i;
    logic [block_width_p-1:0]   mem_cmd_data_i;
    logic [payload_width_p-1:0] mem_cmd_payload_i;

    logic                       mem_resp_v_o;
    logic                       mem_resp_yumi_i;
    logic                       mem_resp_opcode_o;
    logic [paddr_width_p-1:0]   mem_resp_addr_o;
    logic [block_width_p-1:0]   mem_resp_data_o;
    logic [payload_width_p-1:0] mem_resp_payload_o;

    modport master (
        output mem_cmd_v_i, mem_cmd_opcode_i, mem_cmd_addr_i, mem_cmd_data_i,
               mem_cmd_payload_i, mem_resp_yumi_i,
        input  mem_cmd_ready_o, mem_resp_v_o, mem_resp_opcode_o, mem_resp_addr_o,
               mem_resp_data_o, mem_resp_payload_o
    );

    modport slave (
        input  mem_cmd_v_i, mem_cmd_opcode_i, mem_cmd_addr_i, mem_cmd_data_i,
               mem_cmd_payload_i, mem_resp_yumi_i,
        output mem_cmd_ready_o, mem_resp_v_o, mem_resp_opcode_o, mem_resp_addr_o,
               mem_resp_data_o, mem_resp_payload_o
    );
endinterface

// File: rtl/bp_me_mock_mem_responder.sv
// Fixed-latency memory responder: one outstanding command, serviced from an
// internal line array, response held until the initiator yumis it.
module bp_me_mock_mem_responder_chk #(
    parameter int paddr_width_p   = 22,
    parameter int block_width_p   = 512,
    parameter int payload_width_p = 16
) (
    input logic                       clk_i,
    input logic                       reset_n_i,
    input logic                       cmd_ready_i,
    input logic                       resp_v_i,
    input logic                       resp_yumi_i,
    input logic                       resp_opcode_i,
    input logic [paddr_width_p-1:0]   resp_addr_i,
    input logic [block_width_p-1:0]   resp_data_i,
    input logic [payload_width_p-1:0] resp_payload_i
);
    a_no_accept_while_resp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(cmd_ready_i && resp_v_i));

    a_resp_held: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (resp_v_i && !resp_yumi_i) |=> (resp_v_i && $stable(resp_opcode_i)
            && $stable(resp_addr_i) && $stable(resp_data_i) && $stable(resp_payload_i)));
endmodule

module bp_me_mock_mem_responder #(
    parameter int paddr_width_p   = 22,
    parameter int block_width_p   = 512,
    parameter int mem_els_p       = 64,
    parameter int latency_p       = 4,
    parameter int payload_width_p = 16
) (
    input logic                          clk_i,
    input logic                          reset_n_i,
    bp_me_mock_mem_responder_if.slave    mem_if
);
    localparam int offset_width_lp = $clog2(block_width_p / 8);
    localparam int idx_width_lp    = $clog2(mem_els_p);
    localparam int cnt_width_lp    = (latency_p > 1) ? $clog2(latency_p) : 1;
    localparam int cnt_load_int_lp = (latency_p > 1) ? (latency_p - 2) : 0;
    localparam logic [cnt_width_lp-1:0] cnt_load_lp  = cnt_width_lp'(cnt_load_int_lp);
    localparam logic [cnt_width_lp-1:0] cnt_zero_lp  = {cnt_width_lp{1'b0}};
    localparam logic [cnt_width_lp-1:0] cnt_one_lp   = cnt_width_lp'(1'b1);
    localparam logic [block_width_p-1:0] data_zero_lp = {block_width_p{1'b0}};

    typedef enum logic [1:0] {
        E_READY = 2'd0,
        E_WAIT  = 2'd1,
        E_RESP  = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
    logic                       opcode_q, opcode_d;
    logic [paddr_width_p-1:0]   addr_q, addr_d;
    logic [payload_width_p-1:0] payload_q, payload_d;
    logic [block_width_p-1:0]   data_q, data_d;

    logic [block_width_p-1:0]   mem_q [mem_els_p];

    logic                       ready_s;
    logic                       accept_s;
    logic                       resp_v_s;
    logic [idx_width_lp-1:0]    cmd_idx_s;
    logic [idx_width_lp-1:0]    held_idx_s;

    // Ready is gated by reset so nothing can be accepted while reset is held.
    assign ready_s    = reset_n_i & (state_q == E_READY);
    assign resp_v_s   = (state_q == E_RESP);
    assign accept_s   = mem_if.mem_cmd_v_i & ready_s;
    assign cmd_idx_s  = mem_if.mem_cmd_addr_i[offset_width_lp +: idx_width_lp];
    assign held_idx_s = addr_q[offset_width_lp +: idx_width_lp];

    assign mem_if.mem_cmd_ready_o    = ready_s;
    assign mem_if.mem_resp_v_o       = resp_v_s;
    assign mem_if.mem_resp_opcode_o  = opcode_q;
    assign mem_if.mem_resp_addr_o    = addr_q;
    assign mem_if.mem_resp_data_o    = data_q;
    assign mem_if.mem_resp_payload_o = payload_q;

    // Next-state, latency counter and response capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opcode_d  = opcode_q;
        addr_d    = addr_q;
        payload_d = payload_q;
        data_d    = data_q;
        case (state_q)
            E_READY: begin
                if (accept_s) begin
                    opcode_d  = mem_if.mem_cmd_opcode_i;
                    addr_d    = mem_if.mem_cmd_addr_i;
                    payload_d = mem_if.mem_cmd_payload_i;
                    if (latency_p == 1) begin
                        // Read sees the array before this edge; a write returns zero.
                        state_d = E_RESP;
                        data_d  = mem_if.mem_cmd_opcode_i ? data_zero_lp : mem_q[cmd_idx_s];
                    end else begin
                        state_d = E_WAIT;
                        cnt_d   = cnt_load_lp;
                    end
                end else begin
                    state_d = E_READY;
                end
            end
            E_WAIT: begin
                if (cnt_q == cnt_zero_lp) begin
                    state_d = E_RESP;
                    data_d  = opcode_q ? data_zero_lp : mem_q[held_idx_s];
                end else begin
                    cnt_d = cnt_q - cnt_one_lp;
                end
            end
            E_RESP: begin
                if (mem_if.mem_resp_yumi_i) begin
                    state_d = E_READY;
                end else begin
                    state_d = E_RESP;
                end
            end
            default: begin
                state_d = E_READY;
                cnt_d   = cnt_zero_lp;
            end
        endcase
    end

    // Control and response registers; reset drops any in-flight transaction.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= E_READY;
            cnt_q     <= cnt_zero_lp;
            opcode_q  <= 1'b0;
            addr_q    <= {paddr_width_p{1'b0}};
            payload_q <= {payload_width_p{1'b0}};
            data_q    <= data_zero_lp;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opcode_q  <= opcode_d;
            addr_q    <= addr_d;
            payload_q <= payload_d;
            data_q    <= data_d;
        end
    end

    // Line array write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (accept_s && mem_if.mem_cmd_opcode_i) begin
            mem_q[cmd_idx_s] <= mem_if.mem_cmd_data_i;
        end
    end

    bp_me_mock_mem_responder_chk #(
        .paddr_width_p  (paddr_width_p),
        .block_width_p  (block_width_p),
        .payload_width_p(payload_width_p)
    ) u_chk (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .cmd_ready_i   (ready_s),
        .resp_v_i      (resp_v_s),
        .resp_yumi_i   (mem_if.mem_resp_yumi_i),
        .resp_opcode_i (opcode_q),
        .resp_addr_i   (addr_q),
        .resp_data_i   (data_q),
        .resp_payload_i(payload_q)
    );
endmodule
